// File: rtl/axi_burst_writer.sv
// AXI4 write-burst master: one command in, one INCR burst out on AW/W/B, completion pulse back.
// Beat data is a 32-bit incrementing pattern seeded by the command. Bursts crossing 4 KB are refused.
module axi_burst_writer #(
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              START,
    input  logic [31:0]                       START_ADDR,
    input  logic [7:0]                        START_LEN,
    input  logic [31:0]                       START_SEED,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [1:0]                        RESP_OUT,
    output logic                              ERROR,
    output logic                              M_AXI_AWID,
    output logic [31:0]                       M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic [1:0]                        M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WUSER,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic                              M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BUSER,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int          BYTES      = C_M_AXI_DATA_WIDTH / 8;
    localparam int          LSB        = $clog2(BYTES);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << LSB) - 32'd1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN, S_REJECT} state_t;

    state_t      state_reg, state_next;
    logic        awvalid_reg, awvalid_next;
    logic [31:0] awaddr_reg, awaddr_next;
    logic [7:0]  awlen_reg, awlen_next;
    logic        wvalid_reg, wvalid_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        wlast_reg, wlast_next;
    logic [7:0]  beat_reg, beat_next;
    logic        bready_reg, bready_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [1:0]  resp_reg, resp_next;
    logic        error_reg, error_next;

    logic [31:0] aligned_addr;
    logic [13:0] span;
    logic [13:0] end_off;
    logic        crosses_4k;
    logic        unused_inputs;

    assign unused_inputs = &{1'b0, M_AXI_BID, M_AXI_BUSER};

    // Burst end offset within its 4 KB page; landing exactly on 4096 is still legal.
    assign aligned_addr = START_ADDR & ALIGN_MASK;
    assign span         = ({6'd0, START_LEN} + 14'd1) << LSB;
    assign end_off      = {2'b00, aligned_addr[11:0]} + span;
    assign crosses_4k   = end_off > 14'd4096;

    always_comb begin
        state_next   = state_reg;
        awvalid_next = awvalid_reg;
        awaddr_next  = awaddr_reg;
        awlen_next   = awlen_reg;
        wvalid_next  = wvalid_reg;
        wdata_next   = wdata_reg;
        wlast_next   = wlast_reg;
        beat_next    = beat_reg;
        bready_next  = bready_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        resp_next    = resp_reg;
        error_next   = error_reg;
        case (state_reg)
            S_ADDR: begin
                if (M_AXI_AWREADY) begin
                    awvalid_next = 1'b0;
                    wvalid_next  = 1'b1;
                    beat_next    = 8'd0;
                    wlast_next   = (awlen_reg == 8'd0);
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (M_AXI_WREADY) begin
                    if (wlast_reg) begin
                        wvalid_next = 1'b0;
                        wlast_next  = 1'b0;
                        bready_next = 1'b1;
                        state_next  = S_RESP;
                    end else begin
                        beat_next  = beat_reg + 8'd1;
                        wdata_next = wdata_reg + 32'd1;
                        wlast_next = ((beat_reg + 8'd1) == awlen_reg);
                    end
                end
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_next = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    resp_next   = M_AXI_BRESP;
                    if (M_AXI_BRESP != 2'b00)
                        error_next = 1'b1;
                    state_next  = S_FIN;
                end
            end
            default: begin
                // IDLE, FIN and REJECT all accept a new command in the same cycle.
                state_next = S_IDLE;
                if (START) begin
                    awaddr_next = aligned_addr;
                    awlen_next  = START_LEN;
                    wdata_next  = START_SEED;
                    if (crosses_4k) begin
                        done_next  = 1'b1;
                        resp_next  = 2'b10;
                        error_next = 1'b1;
                        state_next = S_REJECT;
                    end else begin
                        awvalid_next = 1'b1;
                        busy_next    = 1'b1;
                        state_next   = S_ADDR;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg   <= S_IDLE;
            awvalid_reg <= 1'b0;
            awaddr_reg  <= 32'd0;
            awlen_reg   <= 8'd0;
            wvalid_reg  <= 1'b0;
            wdata_reg   <= 32'd0;
            wlast_reg   <= 1'b0;
            beat_reg    <= 8'd0;
            bready_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            resp_reg    <= 2'b00;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            awvalid_reg <= awvalid_next;
            awaddr_reg  <= awaddr_next;
            awlen_reg   <= awlen_next;
            wvalid_reg  <= wvalid_next;
            wdata_reg   <= wdata_next;
            wlast_reg   <= wlast_next;
            beat_reg    <= beat_next;
            bready_reg  <= bready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            resp_reg    <= resp_next;
            error_reg   <= error_next;
        end
    end

    // Pattern occupies the low 32 bits; wider buses get zero upper words.
    generate
        for (genvar gi = 0; gi < C_M_AXI_DATA_WIDTH / 32; gi++) begin : g_wdata
            if (gi == 0) begin : g_low
                assign M_AXI_WDATA[31:0] = wdata_reg;
            end else begin : g_high
                assign M_AXI_WDATA[gi*32 +: 32] = 32'd0;
            end
        end
    endgenerate

    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = awaddr_reg;
    assign M_AXI_AWLEN   = awlen_reg;
    assign M_AXI_AWSIZE  = 3'(LSB);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 2'b00;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = 1'b0;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_reg;
    assign M_AXI_WUSER   = 1'b0;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = bready_reg;
    assign BUSY          = busy_reg;
    assign DONE          = done_reg;
    assign RESP_OUT      = resp_reg;
    assign ERROR         = error_reg;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Bench for axi_burst_writer: table of single bursts against a zero-wait slave, then
// hand-built sequences for random stalls, START while busy / at DONE, and mid-burst reset.
module tb_axi_burst_writer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        START = 1'b0;
    logic [31:0] START_ADDR = 32'd0;
    logic [7:0]  START_LEN = 8'd0;
    logic [31:0] START_SEED = 32'd0;
    logic        BUSY, DONE, ERROR;
    logic [1:0]  RESP_OUT;
    logic        AWID, AWUSER, AWVALID, WLAST, WUSER, WVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE, AWPROT;
    logic [1:0]  AWBURST, AWLOCK;
    logic [3:0]  AWCACHE, AWQOS, WSTRB;
    logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [1:0]  BRESP = 2'b00;

    axi_burst_writer #(.C_M_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .START_ADDR(START_ADDR),
        .START_LEN(START_LEN), .START_SEED(START_SEED), .BUSY(BUSY), .DONE(DONE),
        .RESP_OUT(RESP_OUT), .ERROR(ERROR),
        .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
        .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE),
        .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS), .M_AXI_AWUSER(AWUSER),
        .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WUSER(WUSER),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BID(1'b0), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(1'b0),
        .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Command context, written only by the test process.
    int          cmd_id = 0;
    int          c0 = 0;
    int          exp_len = 0;
    logic [31:0] exp_seed = 32'd0;
    logic [1:0]  cfg_bresp = 2'b00;
    bit          rnd_mode = 1'b0;

    // Slave model and monitor state, written only by the negedge process.
    int          seen_id = 0;
    int          aw_count, beat_idx, wlast_count, data_errs, order_errs, stall_errs;
    int          done_count, done_rel, const_errs;
    logic [31:0] aw_addr, beat2, prev_wdata;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  done_resp;
    bit          w_stall, prev_wlast, b_pending, b_hs;

    always @(negedge ACLK) begin
        if (cmd_id != seen_id) begin
            seen_id = cmd_id;
            aw_count = 0; beat_idx = 0; wlast_count = 0; data_errs = 0; order_errs = 0;
            stall_errs = 0; done_count = 0; done_rel = -1; const_errs = 0;
            aw_addr = 32'd0; aw_len = 8'd0; aw_size = 3'd0; beat2 = 32'hDEADBEEF;
            done_resp = 2'b00; w_stall = 1'b0;
        end
        if (ARESET) begin
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
            b_pending = 1'b0; b_hs = 1'b0; w_stall = 1'b0;
        end else begin
            if (b_hs) begin BVALID = 1'b0; b_hs = 1'b0; end
            AWREADY = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
            WREADY  = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (b_pending && !BVALID && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
                BVALID = 1'b1; b_pending = 1'b0;
            end
            BRESP = cfg_bresp;
            if (AWVALID && AWREADY) begin
                aw_count++; aw_addr = AWADDR; aw_len = AWLEN; aw_size = AWSIZE;
                if (AWBURST != 2'b01 || AWCACHE != 4'b0011 || AWID || AWLOCK != 2'b00) const_errs++;
            end
            if (WVALID) begin
                if (aw_count == 0) order_errs++;
                if (WSTRB != 4'hF) const_errs++;
                if (w_stall && (WDATA != prev_wdata || WLAST != prev_wlast)) stall_errs++;
                if (WREADY) begin
                    if (WDATA !== exp_seed + 32'(beat_idx)) data_errs++;
                    if (WLAST !== (beat_idx == exp_len)) data_errs++;
                    if (beat_idx == 2) beat2 = WDATA;
                    beat_idx++;
                    if (WLAST) begin wlast_count++; b_pending = 1'b1; end
                    w_stall = 1'b0;
                end else begin
                    w_stall = 1'b1; prev_wdata = WDATA; prev_wlast = WLAST;
                end
            end else if (beat_idx > 0 && beat_idx <= exp_len) begin
                stall_errs++;
            end
            if (BVALID && BREADY) b_hs = 1'b1;
            if (DONE && cyc > c0) begin
                done_count++;
                if (done_count == 1) begin done_rel = cyc - c0; done_resp = RESP_OUT; end
            end
        end
    end

    int    n_tests = 0;
    int    n_fail = 0;
    string vname = "reset";

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", vname, what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_cmd(input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] seed, input logic [1:0] bresp);
        START = 1'b1; START_ADDR = addr; START_LEN = len; START_SEED = seed;
        cfg_bresp = bresp; exp_seed = seed; exp_len = int'(len);
        c0 = cyc; cmd_id++;
    endtask

    task automatic finish_cmd(input logic [31:0] exp_addr, input bit rej, input int exp_done,
                              input logic [1:0] exp_resp, input bit exp_err, input int budget);
        for (int i = 0; i < budget && done_count == 0; i++) tick();
        chk("done_seen", 64'(done_count > 0), 64'd1);
        repeat (3) tick();
        chk("done_count", 64'(done_count), 64'd1);
        if (rej) begin
            chk("aw_count", 64'(aw_count), 64'd0);
            chk("beats", 64'(beat_idx), 64'd0);
        end else begin
            chk("aw_count", 64'(aw_count), 64'd1);
            chk("awaddr", 64'(aw_addr), 64'(exp_addr));
            chk("awlen", 64'(aw_len), 64'(exp_len));
            chk("awsize", 64'(aw_size), 64'd2);
            chk("beats", 64'(beat_idx), 64'(exp_len + 1));
            chk("wlast_count", 64'(wlast_count), 64'd1);
            chk("data_errs", 64'(data_errs), 64'd0);
            chk("w_before_aw", 64'(order_errs), 64'd0);
            chk("w_stall_errs", 64'(stall_errs), 64'd0);
            chk("const_errs", 64'(const_errs), 64'd0);
        end
        if (exp_done >= 0) chk("done_cycle", 64'(done_rel), 64'(exp_done));
        chk("resp_out", 64'(done_resp), 64'(exp_resp));
        chk("error", 64'(ERROR), 64'(exp_err));
        $display("[TB] %s: awaddr=%08h beats=%0d done@%0d resp=%0d error=%0d",
                 vname, aw_addr, beat_idx, done_rel, done_resp, ERROR);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_awvalid"}, 64'(AWVALID), 64'd0);
        chk({tag, "_wvalid"}, 64'(WVALID), 64'd0);
        chk({tag, "_wlast"}, 64'(WLAST), 64'd0);
        chk({tag, "_bready"}, 64'(BREADY), 64'd0);
        chk({tag, "_busy"}, 64'(BUSY), 64'd0);
        chk({tag, "_done"}, 64'(DONE), 64'd0);
        chk({tag, "_resp"}, 64'(RESP_OUT), 64'd0);
        chk({tag, "_error"}, 64'(ERROR), 64'd0);
        chk({tag, "_awaddr"}, 64'(AWADDR), 64'd0);
        chk({tag, "_wdata"}, 64'(WDATA), 64'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] seed;
        logic [1:0]  bresp;
        logic [31:0] exp_awaddr;
        bit          exp_rej;
        int          exp_done;
        logic [1:0]  exp_resp;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_1000, 8'd3,  32'h0000_00A0, 2'b00, 32'h0000_1000, 1'b0, 7,  2'b00, 1'b0};
        vecs[1] = '{32'h0000_2003, 8'd0,  32'h0000_0005, 2'b00, 32'h0000_2000, 1'b0, 4,  2'b00, 1'b0};
        vecs[2] = '{32'h0000_3F00, 8'd63, 32'h1234_5678, 2'b00, 32'h0000_3F00, 1'b0, 67, 2'b00, 1'b0};
        vecs[3] = '{32'h0000_0FF8, 8'd3,  32'h0000_00A0, 2'b00, 32'h0000_0000, 1'b1, 1,  2'b10, 1'b1};
        vecs[4] = '{32'h0000_1000, 8'd1,  32'hFFFF_FFFF, 2'b10, 32'h0000_1000, 1'b0, 5,  2'b10, 1'b1};
        vecs[5] = '{32'h0000_4000, 8'd2,  32'h0000_0000, 2'b00, 32'h0000_4000, 1'b0, 6,  2'b00, 1'b1};
        vecs[6] = '{32'h0000_5FFE, 8'd0,  32'h0000_0009, 2'b11, 32'h0000_5FFC, 1'b0, 4,  2'b11, 1'b1};
        vecs[7] = '{32'h0000_5FFC, 8'd1,  32'h0000_0009, 2'b00, 32'h0000_0000, 1'b1, 1,  2'b10, 1'b1};

        repeat (3) tick();
        check_all_zero("rst");
        ARESET = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            vname = $sformatf("vec%0d", i);
            start_cmd(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].bresp);
            tick();
            START = 1'b0;
            finish_cmd(vecs[i].exp_awaddr, vecs[i].exp_rej, vecs[i].exp_done,
                       vecs[i].exp_resp, vecs[i].exp_err, 200);
        end

        // Long burst with random AW/W/B waits and a data seed that wraps at beat 2.
        vname = "rand256";
        rnd_mode = 1'b1;
        start_cmd(32'h0000_0000, 8'd255, 32'hFFFF_FFFE, 2'b00);
        tick();
        START = 1'b0;
        finish_cmd(32'h0000_0000, 1'b0, -1, 2'b00, 1'b1, 4000);
        chk("beat2_wrap", 64'(beat2), 64'd0);
        rnd_mode = 1'b0;

        // START pulsed while the burst is in its data phase must be dropped.
        vname = "busy_start";
        start_cmd(32'h0000_6000, 8'd7, 32'h0000_0010, 2'b00);
        tick();
        START = 1'b0;
        repeat (2) tick();
        chk("in_data", 64'(WVALID), 64'd1);
        START = 1'b1; START_ADDR = 32'h0000_7000; START_LEN = 8'd1;
        tick();
        START = 1'b0;
        finish_cmd(32'h0000_6000, 1'b0, 11, 2'b00, 1'b1, 100);

        // START in the same cycle as DONE is accepted immediately.
        vname = "start_at_done";
        start_cmd(32'h0000_6100, 8'd2, 32'h0000_0020, 2'b00);
        tick();
        START = 1'b0;
        for (int i = 0; i < 50 && !DONE; i++) tick();
        chk("first_done", 64'(DONE), 64'd1);
        start_cmd(32'h0000_7000, 8'd1, 32'h0000_0055, 2'b00);
        tick();
        START = 1'b0;
        chk("awvalid_next", 64'(AWVALID), 64'd1);
        chk("awaddr_next", 64'(AWADDR), 64'h7000);
        finish_cmd(32'h0000_7000, 1'b0, 5, 2'b00, 1'b1, 100);

        // Reset on beat 2 of 8 clears everything, including the sticky ERROR.
        vname = "mid_reset";
        start_cmd(32'h0000_8000, 8'd7, 32'h0000_0100, 2'b00);
        tick();
        START = 1'b0;
        repeat (3) tick();
        chk("pre_wvalid", 64'(WVALID), 64'd1);
        chk("pre_wdata", 64'(WDATA), 64'h102);
        ARESET = 1'b1;
        tick();
        check_all_zero("mid_rst");
        ARESET = 1'b0;
        tick();
        vname = "post_reset";
        start_cmd(32'h0000_9000, 8'd2, 32'h0000_0077, 2'b00);
        tick();
        START = 1'b0;
        finish_cmd(32'h0000_9000, 1'b0, 6, 2'b00, 1'b0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
